// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared seven-segment glyph types and SSD1306 command constants
package display_pkg;

    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_fields_t;

    typedef union packed {
        seg_fields_t seg;
        logic [6:0]  raw;
    } Segments;

    localparam int CHAR_W     = 21;
    localparam int CHAR_PAGES = 4;

    localparam logic [7:0] SET_PAGE   = 8'hB0;
    localparam logic [7:0] SET_COL_LO = 8'h00;
    localparam logic [7:0] SET_COL_HI = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } render_state_t;

endpackage

// File: rtl/decoder_7seg_to_21x32pix.sv
// rtl/decoder_7seg_to_21x32pix.sv - one 8-pixel vertical GDDRAM column of a 21x32 seven-segment glyph
module decoder_7seg_to_21x32pix
    import display_pkg::*;
(
    input  Segments    segments_in,
    input  logic [4:0] index_x,
    input  logic [1:0] index_y,
    output logic [7:0] pixels_column
);

    logic        w_left;
    logic        w_right;
    logic        w_span;
    logic [31:0] w_col;

    // Glyph body spans x 2..17; columns 0,1 and 18..20 are inter-digit spacing.
    assign w_left  = (index_x >= 5'd2)  && (index_x <= 5'd4);
    assign w_right = (index_x >= 5'd15) && (index_x <= 5'd17);
    assign w_span  = (index_x >= 5'd2)  && (index_x <= 5'd17);

    always_comb begin
        w_col = 32'h0;
        if (segments_in.seg.a && w_span)  w_col = w_col | 32'h0000_000E;
        if (segments_in.seg.b && w_right) w_col = w_col | 32'h0001_FFFE;
        if (segments_in.seg.c && w_right) w_col = w_col | 32'h3FFF_C000;
        if (segments_in.seg.d && w_span)  w_col = w_col | 32'h3800_0000;
        if (segments_in.seg.e && w_left)  w_col = w_col | 32'h3FFF_C000;
        if (segments_in.seg.f && w_left)  w_col = w_col | 32'h0001_FFFE;
        if (segments_in.seg.g && w_span)  w_col = w_col | 32'h0001_C000;
    end

    assign pixels_column = w_col[{index_y, 3'b000} +: 8];

endmodule

// File: rtl/digit_row_renderer.sv
// rtl/digit_row_renderer.sv - streams SSD1306 page commands and glyph columns for one row of digits
module digit_row_renderer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int PAGE_BASE  = 0,
    parameter int COL_OFFSET = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  Segments    digits_in [NUM_DIGITS],
    output logic       busy,
    output logic       done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_dc
);

    localparam int             DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0]  LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [4:0]     LAST_X     = 5'(CHAR_W - 1);
    localparam logic [1:0]     LAST_PAGE  = 2'(CHAR_PAGES - 1);
    localparam logic [7:0]     COL        = 8'(COL_OFFSET);
    localparam logic [7:0]     PAGE0      = 8'(PAGE_BASE);

    render_state_t r_state;
    logic [1:0]    r_cmd;
    logic [4:0]    r_x;
    logic [DW-1:0] r_digit;
    logic [1:0]    r_page;
    Segments       r_snap [NUM_DIGITS];

    logic          r_busy;
    logic          r_done;
    logic          r_out_valid;
    logic [7:0]    r_out_data;
    logic          r_out_dc;

    render_state_t w_state;
    logic [1:0]    w_cmd;
    logic [4:0]    w_x;
    logic [DW-1:0] w_digit;
    logic [1:0]    w_page;
    logic          w_hs;
    logic          w_accept;
    logic          w_adv;
    logic          w_last;
    logic [7:0]    w_glyph;
    logic [7:0]    w_byte;
    logic          w_dc;

    assign w_hs     = r_out_valid && out_ready;
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_adv    = w_accept || w_hs;

    // Counters always name the byte on the output register; the decoder looks one byte ahead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_x     <= '0;
            r_digit <= '0;
            r_page  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= '0;
        end else begin
            r_state <= w_state;
            r_cmd   <= w_cmd;
            r_x     <= w_x;
            r_digit <= w_digit;
            r_page  <= w_page;
            if (w_accept) r_snap <= digits_in;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cmd   = r_cmd;
        w_x     = r_x;
        w_digit = r_digit;
        w_page  = r_page;
        w_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state = ST_CMD;
                    w_cmd   = '0;
                    w_x     = '0;
                    w_digit = '0;
                    w_page  = '0;
                end
            end
            ST_CMD: begin
                if (w_hs) begin
                    if (r_cmd == 2'd2) begin
                        w_state = ST_DATA;
                        w_cmd   = '0;
                    end else begin
                        w_cmd = r_cmd + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (r_x != LAST_X) begin
                        w_x = r_x + 5'd1;
                    end else begin
                        w_x = '0;
                        if (r_digit != LAST_DIGIT) begin
                            w_digit = r_digit + 1'b1;
                        end else begin
                            w_digit = '0;
                            if (r_page != LAST_PAGE) begin
                                w_state = ST_CMD;
                                w_page  = r_page + 2'd1;
                            end else begin
                                w_state = ST_IDLE;
                                w_page  = '0;
                                w_last  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    decoder_7seg_to_21x32pix u_decoder (
        .segments_in   (r_snap[w_digit]),
        .index_x       (w_x),
        .index_y       (w_page),
        .pixels_column (w_glyph)
    );

    always_comb begin
        w_byte = 8'h00;
        w_dc   = 1'b0;
        case (w_state)
            ST_CMD: begin
                case (w_cmd)
                    2'd0:    w_byte = SET_PAGE | (PAGE0 + {6'b0, w_page});
                    2'd1:    w_byte = SET_COL_LO | {4'b0, COL[3:0]};
                    default: w_byte = SET_COL_HI | {5'b0, COL[6:4]};
                endcase
            end
            ST_DATA: begin
                w_byte = w_glyph;
                w_dc   = 1'b1;
            end
            default: begin
                w_byte = 8'h00;
                w_dc   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_dc    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_adv) begin
                r_busy      <= (w_state != ST_IDLE);
                r_out_valid <= (w_state != ST_IDLE);
                r_out_data  <= w_byte;
                r_out_dc    <= w_dc;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dc    = r_out_dc;

endmodule

// File: tb/tb_digit_row_renderer.sv
// tb/tb_digit_row_renderer.sv - self-checking bench for digit_row_renderer
module tb_digit_row_renderer;
    import display_pkg::*;

    localparam int ND    = 6;
    localparam int TOTAL = 12 + 4 * ND * 21;

    typedef struct {
        string      name;
        int         pos;
        logic [8:0] exp;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    Segments    digits_in [ND];
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_dc;

    int n_pass;
    int n_total;

    logic [8:0] cap [$];
    logic [8:0] exp_q [$];
    vec_t       tbl [$];
    int         first_c, last_c, done_c, stall_err, busy_err;

    logic [6:0] d_blank [ND];
    logic [6:0] d_main  [ND];
    logic [6:0] d_alt   [ND];

    digit_row_renderer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .digits_in (digits_in),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dc    (out_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic set_digits(input logic [6:0] v [ND]);
        for (int i = 0; i < ND; i++) digits_in[i].raw = v[i];
    endtask

    function automatic bit lit(input logic [6:0] s, input int x, input int y);
        bit left  = (x >= 2) && (x <= 4);
        bit right = (x >= 15) && (x <= 17);
        bit span  = (x >= 2) && (x <= 17);
        bit up    = (y >= 1) && (y <= 16);
        bit lo    = (y >= 14) && (y <= 29);
        return (s[0] && span && y >= 1 && y <= 3) || (s[1] && right && up) ||
               (s[2] && right && lo) || (s[3] && span && y >= 27 && y <= 29) ||
               (s[4] && left && lo) || (s[5] && left && up) ||
               (s[6] && span && y >= 14 && y <= 16);
    endfunction

    task automatic build_exp(input logic [6:0] v [ND]);
        logic [7:0] b;
        exp_q.delete();
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
            exp_q.push_back(9'h001);
            exp_q.push_back(9'h010);
            for (int d = 0; d < ND; d++)
                for (int x = 0; x < 21; x++) begin
                    for (int k = 0; k < 8; k++) b[k] = lit(v[d], x, p * 8 + k);
                    exp_q.push_back({1'b1, b});
                end
        end
    endtask

    task automatic compare_frame(input string name);
        int errs = 0;
        check({name, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) errs++;
        check({name, "_bytes_wrong"}, errs, 0);
    endtask

    task automatic apply_table(input string name);
        for (int i = 0; i < tbl.size(); i++)
            check({name, "_", tbl[i].name},
                  (tbl[i].pos < cap.size()) ? 32'(cap[tbl[i].pos]) : 32'hDEAD, 32'(tbl[i].exp));
    endtask

    // Called at a negedge; leaves the bench at the negedge where the first byte is shown.
    task automatic start_frame();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic collect(input bit bp, input bit poke, input int stop_at, input int budget);
        bit         prev_stall = 1'b0;
        logic [8:0] prev_b     = '0;
        bit         ended      = 1'b0;
        cap.delete();
        stall_err = 0; busy_err = 0; first_c = -1; last_c = -1; done_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin done_c = c; ended = 1'b1; break; end
            if (stop_at > 0 && cap.size() == stop_at) begin ended = 1'b1; break; end
            if (!busy) busy_err++;
            if (prev_stall && (!out_valid || {out_dc, out_data} !== prev_b)) stall_err++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke && (c == 40);
            if (poke && c == 40) set_digits(d_alt);
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                cap.push_back({out_dc, out_data});
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = {out_dc, out_data};
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("frame_terminated", ended, 1);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        d_blank = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        d_main  = '{7'h7F, 7'h06, 7'h3F, 7'h6D, 7'h07, 7'h5B};
        d_alt   = '{7'h5B, 7'h07, 7'h6D, 7'h3F, 7'h06, 7'h7F};
        set_digits(d_blank);

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_dc", out_dc, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_done", done, 0);

        // Blank frame
        start_frame();
        check("lat_busy", busy, 1);
        check("lat_valid", out_valid, 1);
        check("lat_byte", {out_dc, out_data}, 9'h0B0);
        collect(1'b0, 1'b0, 0, 2000);
        build_exp(d_blank);
        compare_frame("blank");
        check("blank_no_bubbles", last_c - first_c, TOTAL - 1);
        check("blank_done_gap", done_c - last_c, 1);
        check("blank_busy_at_done", busy, 0);
        check("blank_valid_at_done", out_valid, 0);
        tbl.delete();
        tbl.push_back('{"p0_page",   0,   9'h0B0});
        tbl.push_back('{"p0_col_lo", 1,   9'h001});
        tbl.push_back('{"p0_col_hi", 2,   9'h010});
        tbl.push_back('{"p0_first",  3,   9'h100});
        tbl.push_back('{"p0_last",   128, 9'h100});
        tbl.push_back('{"p1_page",   129, 9'h0B1});
        tbl.push_back('{"p1_col_lo", 130, 9'h001});
        tbl.push_back('{"p1_col_hi", 131, 9'h010});
        tbl.push_back('{"p2_page",   258, 9'h0B2});
        tbl.push_back('{"p3_page",   387, 9'h0B3});
        tbl.push_back('{"last_byte", 515, 9'h100});
        apply_table("blank");
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // Digit content {8,1,0,5,7,2}
        set_digits(d_main);
        start_frame();
        collect(1'b0, 1'b0, 0, 2000);
        build_exp(d_main);
        compare_frame("digits");
        tbl.delete();
        tbl.push_back('{"d0_x0_p0",  3,   9'h100});
        tbl.push_back('{"d0_x2_p0",  5,   9'h1FE});
        tbl.push_back('{"d0_x8_p0",  11,  9'h10E});
        tbl.push_back('{"d0_x20_p0", 23,  9'h100});
        tbl.push_back('{"d1_x8_p0",  32,  9'h100});
        tbl.push_back('{"d1_x16_p0", 40,  9'h1FE});
        tbl.push_back('{"d0_x8_p1",  140, 9'h1C0});
        tbl.push_back('{"d0_x2_p3",  392, 9'h13F});
        tbl.push_back('{"d0_x8_p3",  398, 9'h138});
        apply_table("digits");
        @(negedge clk);

        // Backpressure
        start_frame();
        collect(1'b1, 1'b0, 0, 6000);
        compare_frame("bp");
        check("bp_stall_unstable", stall_err, 0);
        check("bp_busy_dropped", busy_err, 0);
        @(negedge clk);

        // Mid-frame start ignored, digits_in snapshot, start on done cycle
        start_frame();
        collect(1'b0, 1'b1, 0, 2000);
        compare_frame("snapshot");
        check("snapshot_busy", busy_err, 0);
        start_frame();
        check("restart_on_done_byte", {out_dc, out_data}, 9'h0B0);
        check("restart_on_done_busy", busy, 1);
        collect(1'b0, 1'b0, 0, 2000);
        build_exp(d_alt);
        compare_frame("restart");
        @(negedge clk);

        // Reset during page 2 data
        set_digits(d_main);
        start_frame();
        collect(1'b0, 1'b0, 300, 2000);
        check("pre_reset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_frame();
        check("post_rst_first", {out_dc, out_data}, 9'h0B0);
        collect(1'b0, 1'b0, 0, 2000);
        build_exp(d_main);
        compare_frame("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/digit_row_renderer.md
# digit_row_renderer

Sequences the 21x32-pixel seven-segment glyph decoder over a row of digits and streams the resulting SSD1306 page-addressing command bytes and GDDRAM data bytes to the display transfer block. It sits between the frequency-counter digit/segment logic (upstream) and the SSD1306 bus serializer (downstream). A frame render is triggered by a start pulse: the block renders one complete 4-page-high digit row and then signals done.

## Interface
- `NUM_DIGITS`, default 6: digits per row; `NUM_DIGITS*21` must be ≤ 128.
- `PAGE_BASE`, default 0: first SSD1306 page of the row (0..4).
- `COL_OFFSET`, default 1: first display column (0..127 − `NUM_DIGITS*21`).
- `clk` input 1: single clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle render request.
- `digits_in` input `Segments [NUM_DIGITS]`: segment patterns; index 0 is the leftmost digit.
- `busy` output 1: render in progress.
- `done` output 1: one-cycle pulse after the last byte is accepted.
- `out_valid` output 1: `out_data`/`out_dc` are valid.
- `out_ready` input 1: downstream accepts the byte.
- `out_data` output 8: byte to the display.
- `out_dc` output 1: 0 = command byte, 1 = GDDRAM data byte.

## Operation
- **States:**
  - IDLE → CMD on `start`.
  - CMD emits 3 bytes, then goes to DATA.
  - DATA emits `NUM_DIGITS*21` bytes.
  - After DATA: if page < 3, go to CMD with page+1; else go to IDLE and pulse `done`.
- **Snapshot:** on start acceptance, `digits_in` is captured into an internal register. Later changes to `digits_in` do not affect the frame in progress.
- **`start` gating:** `start` is ignored unless in IDLE.
- **CMD bytes, in order:**
  - 0xB0 | (`PAGE_BASE` + page)
  - 0x00 | `COL_OFFSET[3:0]`
  - 0x10 | `COL_OFFSET[6:4]`
- **DATA iteration:** digit index 0..`NUM_DIGITS`−1 (outer), x 0..20 (inner).
  - Decoder inputs: `segments_in` = snapshot[digit], `index_x` = x, `index_y` = page.
  - `out_data` = decoder `pixels_column`.
- **Counters:**
  - cmd: 2-bit, 0..2.
  - x: 5-bit, wraps 20→0 and increments digit.
  - digit: `$clog2(NUM_DIGITS)` bits, wraps to 0 at end of page.
  - page: 2-bit, 0..3.
- **Totals:** 12 command bytes plus `4*NUM_DIGITS*21` data bytes. The default configuration emits 516 bytes.
- **Counter advance:** counters advance only on handshake (`out_valid && out_ready`).

## Timing
- **Reset values:** `busy`=0, `done`=0, `out_valid`=0, `out_data`=0x00, `out_dc`=0, state IDLE, all counters 0.
- **Start latency:** `start` sampled high in IDLE at edge N → at edge N+1 `busy`=1, `out_valid`=1, `out_data`=0xB0|`PAGE_BASE`, `out_dc`=0.
- **Registered outputs:** all outputs are registered.
  - The next byte appears the cycle after a handshake.
  - With `out_ready` held high, throughput is 1 byte/cycle with no bubbles, including at CMD↔DATA and page transitions.
- **Backpressure:** while `out_valid && !out_ready`, `out_data` and `out_dc` are held stable and `out_valid` stays high.
- **End of frame:** on the edge where the last data byte is accepted:
  - Next cycle: `done`=1, `busy`=0, `out_valid`=0.
  - The cycle after: `done`=0.
- **`start` on the `done` cycle:** it is accepted, and the new frame begins the following cycle.
- **Mid-frame reset:** `reset_n` low at any time forces reset values immediately (asynchronously). No partial frame resumes.

## Structure
- **Shared package `display_pkg`:**
  - `Segments` type (packed union: individual a..g / raw 7-bit).
  - `CHAR_W`=21, `CHAR_PAGES`=4.
  - SSD1306 command constants: SET_PAGE=0xB0, SET_COL_LO=0x00, SET_COL_HI=0x10.
- **Sub-module:** one instance of the existing glyph decoder `decoder_7seg_to_21x32pix`, driven combinationally from the counters. Its output is registered into `out_data`.
- **Internal logic:** FSM and counters stay in this module. No further sub-modules.

## Test plan
1. **Reset/idle:** hold `reset_n` low, then release with no `start` → all outputs stay at reset values, `busy`=0.
2. **Blank frame:** all digits 0x00, `out_ready`=1, `start` → exactly 516 bytes on consecutive cycles.
   - Command bytes at positions 0–2 are 0xB0, 0x01, 0x10 with `out_dc`=0.
   - Positions 129–131 are 0xB1, 0x01, 0x10.
   - All data bytes are 0x00.
   - `done` pulses once, one cycle after the last byte.
3. **Digit content:** digits {8,1,0,5,7,2}, `out_ready`=1 → every data byte equals a reference decoder model for (digit, x, page). Bytes for x ∈ {0,1,18,19,20} are 0x00.
4. **Backpressure:** `out_ready` randomly low 50% of cycles → same 516-byte sequence as scenario 3. Data is stable across every stall, no byte is lost or duplicated, `busy` stays high throughout.
5. **Ignored/snapshot inputs:** pulse `start` mid-frame and change `digits_in` after start → no restart; output matches the snapshot taken at start. `start` on the `done` cycle launches a second frame beginning with 0xB0.
6. **Mid-frame reset:** assert `reset_n` low during page 2 DATA → `out_valid` and `busy` drop immediately. A subsequent `start` produces a full frame starting at 0xB0.
